if_id_stage: RTL and testbench

IF_ID_STAGE -- requirements
Module: if_id_stage

---
 rtl/if_id_stage_pkg.sv | 33 +++
 rtl/if_id_stage_if.sv | 11 +
 rtl/if_id_stage_dest_decode.sv | 26 ++
 rtl/if_id_stage.sv | 108 ++++++++++
 tb/tb_if_id_stage.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/if_id_stage_pkg.sv
// Shared definitions for the IF/ID pipeline slice.
// Provides the register-file pause codes, reset/NOP constants, the
// opcodes used by destination decode and a saturating-increment helper.
package cpu_defs;

    typedef enum logic [1:0] {
        PAUSE_NO   = 2'b00,
        PAUSE_RS   = 2'b01,
        PAUSE_RT   = 2'b10,
        PAUSE_BOTH = 2'b11
    } pause_e;

    localparam logic [31:0] INIT_32 = 32'h0000_0000;
    localparam logic [31:0] NOP     = 32'h0000_0000;

    localparam logic [5:0] OP_RTYPE  = 6'h00;
    localparam logic [5:0] OP_JAL    = 6'h03;
    localparam logic [5:0] OP_IMM_LO = 6'h08;
    localparam logic [5:0] OP_IMM_HI = 6'h0F;
    localparam logic [5:0] OP_LW     = 6'h23;

    localparam logic [4:0] REG_RA = 5'd31;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        if (v == 32'hFFFF_FFFF) begin
            return v;
        end else begin
            return v + 32'd1;
        end
    endfunction

endpackage

// File: rtl/if_id_stage_if.sv
// Instruction-memory bus between the fetch stage and the instruction memory.
//   imem_addr  : fetch address (current PC), driven by the stage
//   imem_rdata : instruction word at imem_addr, combinational read
// Modports: master = fetch stage, slave = instruction memory.
interface if_id_stage_if;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;

    modport master (output imem_addr, input imem_rdata);
    modport slave  (input imem_addr, output imem_rdata);
endinterface

// File: rtl/if_id_stage_dest_decode.sv
// Destination-register decode for the instruction held in ID (combinational).
//   opcode : instr[31:26]
//   rt, rd : instr[20:16], instr[15:11]
//   dest   : register the instruction will write, 0 when it writes none
module dest_decode
    import cpu_defs::*;
(
    input  logic [5:0] opcode,
    input  logic [4:0] rt,
    input  logic [4:0] rd,
    output logic [4:0] dest
);

    // R-type writes rd, loads/immediate ALU ops write rt, JAL writes $ra.
    always_comb begin
        dest = 5'd0;
        case (opcode) inside
            OP_RTYPE:               dest = rd;
            OP_LW:                  dest = rt;
            [OP_IMM_LO:OP_IMM_HI]:  dest = rt;
            OP_JAL:                 dest = REG_RA;
            default:                dest = 5'd0;
        endcase
    end

endmodule

// File: rtl/if_id_stage.sv
// IF/ID pipeline stage: program counter, fetch, and the IF/ID register.
// Optional feature macro: BRANCH_DELAY_SLOT_EN
//   defined   -> the word fetched during a redirect is kept (delay slot)
//   undefined -> the word fetched during a redirect is squashed
// Ports:
//   clk, rst        : clock, synchronous active-low reset
//   pause           : hazard request from the register file (PAUSE_*)
//   branch_taken    : redirect request, branch_target its address
//   imem            : instruction-memory bus (master side)
//   id_instr/id_pc/id_valid : ID-stage instruction, PC, validity
//   read_addr1/2    : rs/rt of the ID instruction
//   collision_addr  : destination of the ID instruction (0 if none/stalled)
//   stall_cnt       : saturating count of stall cycles
module if_id_stage
    import cpu_defs::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           pause,
    input  logic                 branch_taken,
    input  logic [31:0]          branch_target,
    if_id_stage_if.master        imem,
    output logic [31:0]          id_instr,
    output logic [31:0]          id_pc,
    output logic                 id_valid,
    output logic [4:0]           read_addr1,
    output logic [4:0]           read_addr2,
    output logic [4:0]           collision_addr,
    output logic [31:0]          stall_cnt
);

    logic [31:0] pc_r, id_instr_r, id_pc_r, stall_cnt_r;
    logic        id_valid_r;
    logic [31:0] pc_s, id_instr_s, id_pc_s, stall_cnt_s;
    logic        id_valid_s;
    logic        stall_s;
    logic [4:0]  dest_s;
    logic        unused_bits_s;

    assign stall_s = (pause != PAUSE_NO);

    // Next-state selection: a stall freezes everything (and masks redirects).
    always_comb begin
        pc_s        = pc_r;
        id_instr_s  = id_instr_r;
        id_pc_s     = id_pc_r;
        id_valid_s  = id_valid_r;
        stall_cnt_s = stall_cnt_r;
        if (stall_s) begin
            stall_cnt_s = sat_inc32(stall_cnt_r);
        end else if (branch_taken) begin
            pc_s    = branch_target;
            id_pc_s = pc_r;
`ifdef BRANCH_DELAY_SLOT_EN
            id_instr_s = imem.imem_rdata;
            id_valid_s = 1'b1;
`else
            id_instr_s = NOP;
            id_valid_s = 1'b0;
`endif
        end else begin
            pc_s       = pc_r + 32'd4;
            id_instr_s = imem.imem_rdata;
            id_pc_s    = pc_r;
            id_valid_s = 1'b1;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_r        <= RESET_PC;
            id_instr_r  <= INIT_32;
            id_pc_r     <= INIT_32;
            id_valid_r  <= 1'b0;
            stall_cnt_r <= INIT_32;
        end else begin
            pc_r        <= pc_s;
            id_instr_r  <= id_instr_s;
            id_pc_r     <= id_pc_s;
            id_valid_r  <= id_valid_s;
            stall_cnt_r <= stall_cnt_s;
        end
    end

    dest_decode u_dest_decode (
        .opcode (id_instr_r[31:26]),
        .rt     (id_instr_r[20:16]),
        .rd     (id_instr_r[15:11]),
        .dest   (dest_s)
    );

    // Low instruction bits (shamt/funct) are not needed by this stage.
    assign unused_bits_s = ^id_instr_r[10:0];

    assign imem.imem_addr = pc_r;
    assign id_instr       = id_instr_r;
    assign id_pc          = id_pc_r;
    assign id_valid       = id_valid_r;
    assign stall_cnt      = stall_cnt_r;
    assign read_addr1     = id_instr_r[25:21];
    assign read_addr2     = id_instr_r[20:16];
    // Zero during a stall so the register-file history drains one entry per cycle.
    assign collision_addr = (id_valid_r && !stall_s) ? dest_s : 5'd0;

endmodule

// File: tb/tb_if_id_stage.sv
module tb_if_id_stage;
    import cpu_defs::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  pause;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [31:0] id_instr, id_pc, stall_cnt;
    logic        id_valid;
    logic [4:0]  read_addr1, read_addr2, collision_addr;

    if_id_stage_if ifc ();

    if_id_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .rst            (rst),
        .pause          (pause),
        .branch_taken   (branch_taken),
        .branch_target  (branch_target),
        .imem           (ifc.master),
        .id_instr       (id_instr),
        .id_pc          (id_pc),
        .id_valid       (id_valid),
        .read_addr1     (read_addr1),
        .read_addr2     (read_addr2),
        .collision_addr (collision_addr),
        .stall_cnt      (stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] instr;
        logic [31:0] ipc;
        logic        valid;
        logic [4:0]  ra1;
        logic [4:0]  ra2;
        logic [4:0]  coll;
        logic [31:0] scnt;
    } exp_t;

    exp_t exp_q[$];
    int tests = 0;
    int fails = 0;

    // Reference model state: architectural view of the stage.
    logic [31:0] m_pc, m_instr, m_ipc, m_scnt;
    logic        m_valid;

    // Register an instruction writes, from the opcode table.
    function automatic logic [4:0] ref_dest(input logic [31:0] ins);
        int op;
        op = int'(ins[31:26]);
        if (op == 0)                 return ins[15:11];
        else if (op == 35)           return ins[20:16];
        else if (op >= 8 && op <= 15) return ins[20:16];
        else if (op == 3)            return 5'd31;
        else                          return 5'd0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, queue the expected outputs, advance the model.
    task automatic step(input logic r, input logic [1:0] p, input logic b,
                        input logic [31:0] tgt, input logic [31:0] rd);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r; pause = p; branch_taken = b; branch_target = tgt;
        ifc.imem_rdata = rd;
        e.addr  = m_pc;
        e.instr = m_instr;
        e.ipc   = m_ipc;
        e.valid = m_valid;
        e.ra1   = m_instr[25:21];
        e.ra2   = m_instr[20:16];
        e.coll  = (m_valid && p == 2'b00) ? ref_dest(m_instr) : 5'd0;
        e.scnt  = m_scnt;
        exp_q.push_back(e);
        if (!r) begin
            m_pc = 32'h0; m_instr = 32'h0; m_ipc = 32'h0; m_valid = 1'b0; m_scnt = 32'h0;
        end else if (p != 2'b00) begin
            if (m_scnt != 32'hFFFF_FFFF) m_scnt = m_scnt + 32'd1;
        end else if (b) begin
            m_ipc = m_pc;
            m_pc  = tgt;
`ifdef BRANCH_DELAY_SLOT_EN
            m_instr = rd; m_valid = 1'b1;
`else
            m_instr = 32'h0; m_valid = 1'b0;
`endif
        end else begin
            m_ipc = m_pc; m_pc = m_pc + 32'd4; m_instr = rd; m_valid = 1'b1;
        end
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        logic [5:0]  op;
        w = $urandom;
        case ($urandom_range(0, 5))
            0: op = 6'h00;
            1: op = 6'h03;
            2: op = 6'h23;
            3: op = 6'(6'h08 + 6'($urandom_range(0, 7)));
            4: op = 6'($urandom_range(0, 63));
            default: op = 6'h02;
        endcase
        w[31:26] = op;
        return w;
    endfunction

    // Monitor: mid-cycle, compare every DUT output against the queued expectation.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("imem_addr",      ifc.imem_addr, e.addr);
            chk("id_instr",       id_instr, e.instr);
            chk("id_pc",          id_pc, e.ipc);
            chk("id_valid",       32'(id_valid), 32'(e.valid));
            chk("read_addr1",     32'(read_addr1), 32'(e.ra1));
            chk("read_addr2",     32'(read_addr2), 32'(e.ra2));
            chk("collision_addr", 32'(collision_addr), 32'(e.coll));
            chk("stall_cnt",      stall_cnt, e.scnt);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] t;
        logic [1:0]  p;
        rst = 1'b0; pause = 2'b00; branch_taken = 1'b0; branch_target = 32'h0;
        ifc.imem_rdata = 32'h0;
        repeat (2) @(posedge clk);
        m_pc = 32'h0; m_instr = 32'h0; m_ipc = 32'h0; m_valid = 1'b0; m_scnt = 32'h0;

        // Reset state, then a free-running fetch of zero words.
        step(1'b0, PAUSE_NO, 1'b0, 32'h0, 32'h0);
        repeat (4) step(1'b1, PAUSE_NO, 1'b0, 32'h0, 32'h0);

        // add $3,$1,$2 enters ID, then a two-cycle rs stall.
        step(1'b1, PAUSE_NO, 1'b0, 32'h0, 32'h0022_1820);
        step(1'b1, PAUSE_RS, 1'b0, 32'h0, 32'hDEAD_BEEF);
        step(1'b1, PAUSE_RS, 1'b0, 32'h0, 32'hDEAD_BEEF);
        step(1'b1, PAUSE_NO, 1'b0, 32'h0, 32'h8C22_0004);

        // Branch request during a full stall must be ignored.
        step(1'b1, PAUSE_BOTH, 1'b1, 32'h0000_0100, 32'h1111_1111);
        step(1'b1, PAUSE_NO, 1'b1, 32'h0000_0100, 32'h2402_0005);
        step(1'b1, PAUSE_NO, 1'b0, 32'h0, 32'h0C00_0040);
        step(1'b1, PAUSE_NO, 1'b0, 32'h0, 32'h0000_0000);

        // PC wrap from the top of the address space.
        step(1'b1, PAUSE_NO, 1'b1, 32'hFFFF_FFFC, 32'h0);
        step(1'b1, PAUSE_NO, 1'b0, 32'h0, 32'h2063_0001);
        step(1'b1, PAUSE_NO, 1'b0, 32'h0, 32'h0);
        step(1'b1, PAUSE_NO, 1'b0, 32'h0, 32'h0);

        // Randomized traffic.
        for (int i = 0; i < 300; i++) begin
            t = $urandom;
            t[1:0] = 2'b00;
            p = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            step(($urandom_range(0, 59) != 0), p, ($urandom_range(0, 5) == 0), t, rand_instr());
        end

        // Reset asserted in the middle of a stall, together with a redirect.
        step(1'b1, PAUSE_NO, 1'b0, 32'h0, 32'h0064_2820);
        step(1'b1, PAUSE_RT, 1'b0, 32'h0, 32'h0);
        step(1'b0, PAUSE_RT, 1'b1, 32'h0000_0200, 32'h0);
        step(1'b1, PAUSE_NO, 1'b0, 32'h0, 32'h0);

        @(negedge clk);
        #1;
        chk("scoreboard_drain", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
